// File: rtl/lsu_mem_port.sv
// ---------------------------------------------------------------------------
// lsu_mem_port : load/store initiator driving the data port of the shared RAM
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_mem_port #(
   parameter bit          RMW_SUBWORD = 1'b1,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_web,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      RMW_MERGE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        mask_q, mask_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;

   logic        req_is_b, req_is_h, req_is_w, req_legal, req_mis, req_err;
   logic [3:0]  req_lane;
   logic [31:0] req_repl;
   logic [31:0] mask32;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   // Request decode: legality, alignment, lane mask and replicated store data
   always_comb begin
      req_is_b = (req_funct3[1:0] == 2'b00);
      req_is_h = (req_funct3[1:0] == 2'b01);
      req_is_w = (req_funct3[1:0] == 2'b10);
      if (req_store) begin
         req_legal = (req_funct3[2] == 1'b0) && !(req_funct3[1:0] == 2'b11);
      end else begin
         req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                     (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                     (req_funct3 == 3'b101);
      end
      req_mis = (req_is_h && req_addr[0]) || (req_is_w && (req_addr[1:0] != 2'b00));
      req_err = !req_legal || req_mis;

      req_lane = 4'hF;
      req_repl = req_wdata;
      if (req_is_b) begin
         req_lane = 4'b0001 << req_addr[1:0];
         req_repl = {4{req_wdata[7:0]}};
      end else if (req_is_h) begin
         req_lane = 4'b0011 << {req_addr[1], 1'b0};
         req_repl = {2{req_wdata[15:0]}};
      end
   end

   always_comb begin
      mask32 = {{8{mask_q[3]}}, {8{mask_q[2]}}, {8{mask_q[1]}}, {8{mask_q[0]}}};

      case (addr_q[1:0])
         2'd0:    ld_byte = mem_dout[7:0];
         2'd1:    ld_byte = mem_dout[15:8];
         2'd2:    ld_byte = mem_dout[23:16];
         default: ld_byte = mem_dout[31:24];
      endcase
      ld_half = addr_q[1] ? mem_dout[31:16] : mem_dout[15:0];

      case (funct3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'd0, ld_byte};
         3'b101:  ld_ext = {16'd0, ld_half};
         default: ld_ext = mem_dout;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      funct3_d     = funct3_q;
      wdata_d      = wdata_q;
      mask_d       = mask_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'd0;
      mem_addr     = addr_q;
      mem_web      = 4'h0;
      mem_din      = 32'd0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               mem_addr = req_addr;
               mem_din  = req_repl;
               addr_d   = req_addr;
               funct3_d = req_funct3;
               if (req_err) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (!req_store) begin
                  state_d = LOAD_WAIT;
               end else if (req_is_w || !RMW_SUBWORD) begin
                  mem_web      = req_lane;
                  resp_valid_d = 1'b1;
               end else begin
                  // Sub-word RMW: this cycle is the read half
                  wdata_d = req_repl;
                  mask_d  = req_lane;
                  state_d = RMW_MERGE;
               end
            end
         end
         LOAD_WAIT: begin
            resp_rdata_d = ld_ext;
            resp_valid_d = 1'b1;
            state_d      = IDLE;
         end
         RMW_MERGE: begin
            mem_web      = 4'hF;
            mem_din      = (mem_dout & ~mask32) | (wdata_q & mask32);
            resp_valid_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // No RAM write may escape while reset is held, even mid-RMW
      if (reset) begin
         mem_addr = '0;
         mem_web  = 4'h0;
         mem_din  = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         funct3_q     <= 3'd0;
         wdata_q      <= 32'd0;
         mask_q       <= 4'h0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         funct3_q     <= funct3_d;
         wdata_q      <= wdata_d;
         mask_q       <= mask_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign req_ready  = (state_q == IDLE) && !reset;
   assign busy       = (state_q != IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_port : directed self-checking bench for lsu_mem_port
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsu_mem_port;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_store = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;

   logic        req_ready, resp_valid, resp_err, busy;
   logic [31:0] resp_rdata, mem_addr, mem_din;
   logic [3:0]  mem_web;
   logic [31:0] mem_dout;

   logic        req_ready0, resp_valid0, resp_err0, busy0;
   logic [31:0] resp_rdata0, mem_addr0, mem_din0;
   logic [3:0]  mem_web0;

   int total = 0;
   int bad   = 0;

   logic [31:0] ram [0:511];
   logic        bd_we = 1'b0;
   logic [8:0]  bd_idx = 9'd0;
   logic [31:0] bd_data = 32'd0;

   always #5 clk = ~clk;

   lsu_mem_port #(.RMW_SUBWORD(1'b1), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_web(mem_web), .mem_din(mem_din),
      .mem_dout(mem_dout), .busy(busy)
   );

   lsu_mem_port #(.RMW_SUBWORD(1'b0), .ADDR_W(32)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready0), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
      .mem_addr(mem_addr0), .mem_web(mem_web0), .mem_din(mem_din0),
      .mem_dout(mem_dout), .busy(busy0)
   );

   // Port-B RAM: registered read, byte-enabled write, plus a preload path
   always @(posedge clk) begin
      if (bd_we) begin
         ram[bd_idx] <= bd_data;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (mem_web[i]) ram[mem_addr[10:2]][8*i +: 8] <= mem_din[8*i +: 8];
         end
      end
      mem_dout <= ram[mem_addr[10:2]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      bd_we = 1'b1; bd_idx = addr[10:2]; bd_data = data;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
      @(negedge clk);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = d;
      #1;
   endtask

   task automatic edge_release();
      @(posedge clk); #1;
      req_valid = 1'b0;
      #1;
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
      drive(1'b0, f3, a, 32'd0);
      chk({tag, "_web_n"}, {28'd0, mem_web}, 32'h0);
      chk({tag, "_addr_n"}, mem_addr, a);
      edge_release();
      chk({tag, "_rv_n1"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_busy_n1"}, {31'd0, busy}, 32'd1);
      chk({tag, "_rdy_n1"}, {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      chk({tag, "_rv_n2"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, "_err_n2"}, {31'd0, resp_err}, 32'd0);
      chk({tag, "_rdata"}, resp_rdata, exp);
   endtask

   task automatic do_err(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
      drive(st, f3, a, d);
      chk({tag, "_web_n"}, {28'd0, mem_web}, 32'h0);
      edge_release();
      chk({tag, "_rv"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, "_err"}, {31'd0, resp_err}, 32'd1);
      chk({tag, "_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 512; i++) ram[i] = 32'd0;
      preload(32'h100, 32'h8899AABB);
      preload(32'h300, 32'hDEADBEEF);
      preload(32'h500, 32'h11223344);
      @(negedge clk); #1;
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_web", {28'd0, mem_web}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_din", mem_din, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

      do_load("lb101", 3'b000, 32'h101, 32'hFFFFFFAA);
      do_load("lbu101", 3'b100, 32'h101, 32'h000000AA);
      do_load("lh102", 3'b001, 32'h102, 32'hFFFF8899);
      do_load("lhu102", 3'b101, 32'h102, 32'h00008899);
      do_load("lw100", 3'b010, 32'h100, 32'h8899AABB);

      drive(1'b1, 3'b010, 32'h200, 32'h12345678);
      chk("sw_web", {28'd0, mem_web}, 32'hF);
      chk("sw_din", mem_din, 32'h12345678);
      edge_release();
      chk("sw_rv", {31'd0, resp_valid}, 32'd1);
      chk("sw_rdata", resp_rdata, 32'd0);
      chk("sw_busy", {31'd0, busy}, 32'd0);
      do_load("lw200", 3'b010, 32'h200, 32'h12345678);

      drive(1'b1, 3'b000, 32'h302, 32'h00000055);
      chk("sb_web_n", {28'd0, mem_web}, 32'h0);
      chk("sb0_web_n", {28'd0, mem_web0}, 32'h4);
      chk("sb0_din_n", mem_din0, 32'h55555555);
      edge_release();
      chk("sb_busy", {31'd0, busy}, 32'd1);
      chk("sb_web_n1", {28'd0, mem_web}, 32'hF);
      chk("sb_din_n1", mem_din, 32'hDE55BEEF);
      chk("sb_addr_n1", mem_addr, 32'h302);
      chk("sb_rv_n1", {31'd0, resp_valid}, 32'd0);
      chk("sb0_rv_n1", {31'd0, resp_valid0}, 32'd1);
      @(posedge clk); #1;
      chk("sb_rv_n2", {31'd0, resp_valid}, 32'd1);

      drive(1'b1, 3'b001, 32'h300, 32'h00001234);
      chk("sh0_web_n", {28'd0, mem_web0}, 32'h3);
      chk("sh0_din_n", mem_din0, 32'h12341234);
      edge_release();
      chk("sh_din_n1", mem_din, 32'hDE551234);
      @(posedge clk); #1;
      chk("sh_rv_n2", {31'd0, resp_valid}, 32'd1);
      chk("sh_ram", ram[9'h0C0], 32'hDE551234);

      do_err("lw201", 1'b0, 3'b010, 32'h201, 32'd0);
      do_err("sh203", 1'b1, 3'b001, 32'h203, 32'h0000FFFF);
      chk("sh203_ram", ram[9'h080], 32'h12345678);
      do_err("ld011", 1'b0, 3'b011, 32'h100, 32'd0);
      do_err("sbu100", 1'b1, 3'b100, 32'h100, 32'h000000FF);
      chk("sbu_ram", ram[9'h040], 32'h8899AABB);

      // Back-to-back: load held valid while the store completes
      drive(1'b1, 3'b010, 32'h400, 32'hCAFEF00D);
      chk("b2b_sw_web", {28'd0, mem_web}, 32'hF);
      @(posedge clk); #1;
      chk("b2b_sw_rv", {31'd0, resp_valid}, 32'd1);
      req_store = 1'b0;
      #1;
      chk("b2b_ready", {31'd0, req_ready}, 32'd1);
      edge_release();
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      chk("b2b_rdy_busy", {31'd0, req_ready}, 32'd0);
      chk("b2b_rv_gap", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;
      chk("b2b_lw_rv", {31'd0, resp_valid}, 32'd1);
      chk("b2b_lw_rdata", resp_rdata, 32'hCAFEF00D);

      // Reset during the merge cycle of a sub-word RMW
      drive(1'b1, 3'b000, 32'h500, 32'h000000AA);
      edge_release();
      chk("rmwrst_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rmwrst_web", {28'd0, mem_web}, 32'h0);
      @(posedge clk); #1;
      chk("rmwrst_rv", {31'd0, resp_valid}, 32'd0);
      chk("rmwrst_busy_after", {31'd0, busy}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rmwrst_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      chk("rmwrst_rv2", {31'd0, resp_valid}, 32'd0);
      chk("rmwrst_ram", ram[9'h140], 32'h11223344);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store initiator that drives the data port (port B) of the shared instruction/data RAM on behalf of the CPU memory stage.
- Accepts one load or store request at a time over a valid/ready handshake and drives RAM address, byte write-enable and write data.
- Sign- or zero-extends and lane-aligns load data returned after the RAM's 1-cycle registered read, and reports misaligned accesses.
- Optionally performs read-modify-write so byte and half-word stores never corrupt neighbouring lanes.

Parameters:
- RMW_SUBWORD, 1, 1: sub-word stores use read-merge-full-word-write. 0: sub-word stores issue a single write with lane web and replicated data.
- ADDR_W, 32, request and memory address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal funct3; valid with resp_valid
- mem_addr  out  ADDR_W  RAM port B address
- mem_web  out  4  RAM port B byte write enables; 0 = read
- mem_din  out  32  RAM port B write data
- mem_dout  in  32  RAM port B read data, valid 1 cycle after address is sampled
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, LOAD_WAIT, RMW_MERGE.
- req_ready = (state==IDLE) && !reset. Acceptance = req_valid && req_ready at a rising edge (cycle N).
- In IDLE, mem_addr, mem_web and mem_din are combinational from req_* when req_valid. Otherwise mem_web = 0 and mem_addr holds the last captured address.
- Alignment and legality:
  - H/HU/SH with addr[0]=1 is misaligned.
  - W/SW with addr[1:0]!=0 is misaligned.
  - Loads with funct3 011/11x are illegal; stores with funct3 other than 000/001/010 are illegal.
  - On error: mem_web=0 in cycle N, state stays IDLE, resp_valid=1 and resp_err=1 in cycle N+1, resp_rdata=0.
- Load:
  - Cycle N: mem_web=0; go to LOAD_WAIT and capture addr[1:0] and funct3.
  - Cycle N+1: select lane from mem_dout (byte lane = addr[1:0], half lane = addr[1]); sign-extend B/H, zero-extend BU/HU, W passes through. Register the result and return to IDLE.
  - resp_valid=1 in cycle N+2. Latency is 2 cycles.
- Word store:
  - Cycle N: mem_web=4'hF, mem_din=req_wdata; stay IDLE.
  - resp_valid in cycle N+1.
- Sub-word store with RMW_SUBWORD=0:
  - Cycle N: mem_web = lane mask (SB: 1<<addr[1:0]; SH: 4'b0011<<{addr[1],1'b0}); mem_din = data replicated to every lane.
  - resp_valid in cycle N+1.
- Sub-word store with RMW_SUBWORD=1:
  - Cycle N: mem_web=0 (read); capture addr, data and mask; go to RMW_MERGE.
  - Cycle N+1: mem_addr = captured addr, mem_web=4'hF, mem_din = (mem_dout & ~mask32) | (repl_data & mask32); return to IDLE.
  - resp_valid in cycle N+2.
- Responses and back-to-back operation:
  - resp_valid is high for exactly one cycle per accepted request; responses return in order (one outstanding).
  - A new request may be accepted in the same cycle resp_valid is high when state==IDLE.
- Reset:
  - All outputs go to 0: resp_valid, resp_err, resp_rdata, mem_web, mem_din, mem_addr. busy=0, state=IDLE.
  - reset forces mem_web=0 combinationally, so no write reaches the RAM in any cycle where reset is high, including mid-RMW.
  - An in-flight request is dropped with no response.
- Address bits above [1:0] pass to mem_addr unchanged; wrap is the RAM's concern.

Test Plan:
- Memory word 0x100 = 0x8899AABB; LB addr 0x101 -> resp_valid at N+2, rdata=0xFFFFFFAA; LBU 0x101 -> 0x000000AA; LH 0x102 -> 0xFFFF8899; LW 0x100 -> 0x8899AABB.
- SW 0x200 data 0x12345678 -> mem_web=F and mem_din=0x12345678 in cycle N, resp_valid at N+1; then LW 0x200 -> 0x12345678.
- RMW_SUBWORD=1, word 0x300 = 0xDEADBEEF; SB 0x302 data 0x55 -> cycle N web=0, cycle N+1 web=F with din=0xDE55BEEF, resp at N+2; SH 0x300 data 0x1234 -> word 0xDE551234.
- Misaligned: LW 0x201 -> mem_web=0 throughout, resp_err=1 at N+1, rdata=0; SH 0x203 -> no write, resp_err=1; memory unchanged.
- Back-to-back: SW 0x400 then LW 0x400 presented continuously -> second request accepted in the cycle of the first resp_valid, load returns the stored data; req_ready=0 while busy.
- Reset asserted in the RMW_MERGE cycle of SB 0x500 -> mem_web=0 that cycle, no resp_valid, memory word unchanged, req_ready=1 the cycle after reset deasserts.
